median_job_sequencer: RTL

Controller that runs one complete median-filter job on the histogram/median datapath top.
- Streams a binary image from a host into the raw image memory, then pulses start and waits for fullImageDone.
- Sweeps the x/y histogram out to the host, then streams the filtered image back out with valid/ready backpressure.
- Sits between the host interface logic and the datapath top, and is the sole driver of all datapath control inputs.

---
 rtl/median_job_sequencer_pkg.sv | 18 +
 rtl/median_readout_skid.sv | 53 +++++
 rtl/median_job_sequencer.sv | 170 +++++++++++++++++
 3 files changed

// File: rtl/median_job_sequencer_pkg.sv
// rtl/median_job_sequencer_pkg.sv - shared types and constants for the median job sequencer
package median_job_sequencer_pkg;

    localparam int ADDR_W   = 8;
    localparam int READ_LAT = 1;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_START,
        ST_FILTER,
        ST_HIST,
        ST_READOUT,
        ST_DONE,
        ST_ERR
    } seq_state_e;

endpackage

// File: rtl/median_readout_skid.sv
// rtl/median_readout_skid.sv - 2-entry valid/ready skid buffer for median readout data
module median_readout_skid #(
    parameter int W = 1
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [W-1:0] in_tdata,
    input  logic         in_tvalid,
    output logic [W-1:0] out_tdata,
    output logic         out_tvalid,
    input  logic         out_tready,
    output logic         space_avail
);

    logic [W-1:0] mem [2];
    logic         wr_ptr;
    logic         rd_ptr;
    logic [1:0]   count;
    logic         push;
    logic         pop;

    assign push       = in_tvalid;
    assign out_tvalid = (count != 2'd0);
    assign pop        = out_tvalid & out_tready;
    assign out_tdata  = out_tvalid ? mem[rd_ptr] : '0;

    // A read issued now lands next cycle; the word arriving now already holds a slot.
    assign space_avail = ({1'b0, count} + {2'b00, in_tvalid}) < 3'd2;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            mem[0] <= '0;
            mem[1] <= '0;
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= in_tdata;
                wr_ptr      <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
            case ({push, pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/median_job_sequencer.sv
// rtl/median_job_sequencer.sv - runs one load/filter/histogram/readout job on the median datapath
module median_job_sequencer
    import median_job_sequencer_pkg::*;
#(
    parameter int IMG_W        = 128,
    parameter int IMG_H        = 128,
    parameter int FILT_TIMEOUT = 1048575,
    parameter int HIST_TIMEOUT = 1023
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              job_go,
    input  logic [12:0]       cfg_threshold,
    input  logic              px_valid,
    input  logic              px_data,
    output logic              px_ready,
    output logic [7:0]        hist_x,
    output logic              hist_x_valid,
    output logic [7:0]        hist_y,
    output logic              hist_y_valid,
    output logic              med_valid,
    output logic              med_data,
    input  logic              med_ready,
    output logic              busy,
    output logic              done,
    output logic              timeout_err,
    output logic              ht_writeMem,
    output logic [ADDR_W-1:0] ht_xAddressIn,
    output logic [ADDR_W-1:0] ht_yAddressIn,
    output logic              ht_dataIn,
    output logic              ht_start,
    output logic [12:0]       ht_threshold,
    output logic              ht_readHistogram,
    output logic              ht_readMedianImage,
    input  logic              ht_fullImageDone,
    input  logic              ht_medianDataOut,
    input  logic [7:0]        ht_xHistogramOut,
    input  logic [7:0]        ht_yHistogramOut,
    input  logic              ht_xValid,
    input  logic              ht_yValid
);

    localparam logic [ADDR_W-1:0] X_LAST = ADDR_W'(IMG_W - 1);
    localparam logic [ADDR_W-1:0] Y_LAST = ADDR_W'(IMG_H - 1);
    localparam logic [16:0]       NPIX   = 17'(IMG_W * IMG_H);

    seq_state_e          state, state_nxt;
    logic [ADDR_W-1:0]   x_cnt, y_cnt;
    logic [31:0]         cyc_cnt;
    logic [16:0]         issue_cnt, out_cnt;
    logic [READ_LAT-1:0] rd_pipe;
    logic                hist_seen, timeout_q;
    logic [12:0]         thr_q;
    logic                beat, issue, out_fire, at_last, space_avail;

    assign beat     = (state == ST_LOAD) & px_valid;
    assign issue    = (state == ST_READOUT) & space_avail & (issue_cnt != NPIX);
    assign out_fire = med_valid & med_ready;
    assign at_last  = (x_cnt == X_LAST) & (y_cnt == Y_LAST);

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:    if (job_go) state_nxt = ST_LOAD;
            ST_LOAD:    if (beat && at_last) state_nxt = ST_START;
            ST_START:   state_nxt = ST_FILTER;
            ST_FILTER: begin
                // Completion beats a timeout landing in the same cycle.
                if (ht_fullImageDone)                          state_nxt = ST_HIST;
                else if (cyc_cnt == 32'(FILT_TIMEOUT - 1))     state_nxt = ST_ERR;
            end
            ST_HIST: begin
                if (hist_seen && !ht_xValid && !ht_yValid)     state_nxt = ST_READOUT;
                else if (cyc_cnt == 32'(HIST_TIMEOUT - 1))     state_nxt = ST_ERR;
            end
            ST_READOUT: if (out_fire && out_cnt == NPIX - 17'd1) state_nxt = ST_DONE;
            ST_DONE:    state_nxt = ST_IDLE;
            ST_ERR:     state_nxt = ST_IDLE;
            default:    state_nxt = ST_IDLE;
        endcase
    end

    assign px_ready           = (state == ST_LOAD);
    assign busy               = (state != ST_IDLE);
    assign done               = (state == ST_DONE);
    assign ht_start           = (state == ST_START);
    assign ht_readHistogram   = (state == ST_HIST);
    assign ht_readMedianImage = (state == ST_READOUT);
    assign ht_writeMem        = beat;
    assign ht_dataIn          = beat & px_data;
    assign ht_xAddressIn      = (beat | issue) ? x_cnt : '0;
    assign ht_yAddressIn      = (beat | issue) ? y_cnt : '0;
    assign ht_threshold       = thr_q;
    assign timeout_err        = timeout_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state        <= ST_IDLE;
            x_cnt        <= '0;
            y_cnt        <= '0;
            cyc_cnt      <= '0;
            issue_cnt    <= '0;
            out_cnt      <= '0;
            rd_pipe      <= '0;
            hist_seen    <= 1'b0;
            timeout_q    <= 1'b0;
            thr_q        <= '0;
            hist_x       <= '0;
            hist_y       <= '0;
            hist_x_valid <= 1'b0;
            hist_y_valid <= 1'b0;
        end else begin
            state <= state_nxt;

            if (state_nxt != state || !(state == ST_FILTER || state == ST_HIST))
                cyc_cnt <= '0;
            else
                cyc_cnt <= cyc_cnt + 32'd1;

            if (state == ST_IDLE && job_go) begin
                x_cnt     <= '0;
                y_cnt     <= '0;
                timeout_q <= 1'b0;
                thr_q     <= cfg_threshold;
            end

            if (state == ST_START) begin
                x_cnt     <= '0;
                y_cnt     <= '0;
                issue_cnt <= '0;
                out_cnt   <= '0;
            end

            // Load and readout share one raster walker.
            if (beat || issue) begin
                if (x_cnt == X_LAST) begin
                    x_cnt <= '0;
                    y_cnt <= (y_cnt == Y_LAST) ? '0 : y_cnt + 1'b1;
                end else begin
                    x_cnt <= x_cnt + 1'b1;
                end
            end

            if (issue)    issue_cnt <= issue_cnt + 17'd1;
            if (out_fire) out_cnt   <= out_cnt + 17'd1;
            rd_pipe <= READ_LAT'(issue);

            hist_seen    <= (state == ST_HIST) & (hist_seen | ht_xValid | ht_yValid);
            hist_x       <= (state == ST_HIST) ? ht_xHistogramOut : '0;
            hist_y       <= (state == ST_HIST) ? ht_yHistogramOut : '0;
            hist_x_valid <= (state == ST_HIST) & ht_xValid;
            hist_y_valid <= (state == ST_HIST) & ht_yValid;

            if (state_nxt == ST_ERR && state != ST_ERR)
                timeout_q <= 1'b1;
        end
    end

    median_readout_skid #(.W(1)) u_skid (
        .clk         (clk),
        .reset       (reset),
        .in_tdata    (ht_medianDataOut),
        .in_tvalid   (rd_pipe[READ_LAT-1]),
        .out_tdata   (med_data),
        .out_tvalid  (med_valid),
        .out_tready  (med_ready),
        .space_avail (space_avail)
    );

endmodule
